xfer_sequencer: RTL and testbench

//  Host-clock controller that sequences one SD transaction across the CMD, DAT and ADMA engines.
//  On start_flag it issues the command, waits for the response or a timeout, then launches DAT+DMA.
//  It counts completed blocks, then reports completion or error to the status registers.

---
 rtl/xfer_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_xfer_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xfer_sequencer.sv
// rtl/xfer_sequencer.sv - SD transaction sequencer across CMD/DAT/ADMA engines; optional auto CMD12 via XFER_AUTO_CMD12_EN
module xfer_sequencer #(
    parameter int         BLK_CNT_W   = 16,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [5:0] CMD12_IDX   = 6'd12
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start_flag,
    input  logic [5:0]           cmd_index,
    input  logic                 data_present,
    input  logic                 multiple_blk,
    input  logic [BLK_CNT_W-1:0] block_cnt,
    input  logic                 cmd_complete,
    input  logic                 cmd_timeout,
    input  logic                 blk_done,
    input  logic                 dat_error,
    input  logic                 stop_req,
    output logic                 new_cmd,
    output logic [5:0]           cmd_index_out,
    output logic                 dat_start,
    output logic                 cmd_inhibit,
    output logic                 dat_inhibit,
    output logic                 cmd_done_irq,
    output logic                 xfer_done_irq,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [BLK_CNT_W-1:0] blocks_left
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, CMD_ISSUE, CMD_WAIT, DAT_RUN,
`ifdef XFER_AUTO_CMD12_EN
        STOP_ISSUE, STOP_WAIT,
`endif
        DONE, ERR
    } state_t;

    state_t               state_q, state_n;
    logic [TMR_W-1:0]     timer_q, timer_n;
    logic                 dp_q, dp_n, mb_q, mb_n;
    logic                 timed_out;
    logic                 new_cmd_n, dat_start_n, cmd_irq_n, xfer_irq_n;
    logic                 cmd_inh_n, dat_inh_n, err_n;
    logic [1:0]           code_n;
    logic [5:0]           idx_n;
    logic [BLK_CNT_W-1:0] blocks_n;

`ifndef XFER_AUTO_CMD12_EN
    logic unused_cmd12;
    assign unused_cmd12 = ^CMD12_IDX;
`endif

    always_comb begin
        state_n     = state_q;
        timer_n     = timer_q;
        dp_n        = dp_q;
        mb_n        = mb_q;
        blocks_n    = blocks_left;
        cmd_inh_n   = cmd_inhibit;
        dat_inh_n   = dat_inhibit;
        err_n       = error;
        code_n      = err_code;
        idx_n       = cmd_index_out;
        dat_start_n = 1'b0;
        cmd_irq_n   = 1'b0;
        xfer_irq_n  = 1'b0;
        // Internal timeout takes priority over a response arriving in the same cycle
        timed_out   = cmd_timeout || (timer_q == TMR_LAST);

        case (state_q)
            IDLE: begin
                if (start_flag) begin
                    state_n   = CMD_ISSUE;
                    idx_n     = cmd_index;
                    cmd_inh_n = 1'b1;
                    dat_inh_n = data_present;
                    err_n     = 1'b0;
                    code_n    = 2'd0;
                    dp_n      = data_present;
                    mb_n      = multiple_blk;
                    blocks_n  = multiple_blk ? block_cnt : BLK_CNT_W'(1);
                end
            end
            CMD_ISSUE: begin
                state_n = CMD_WAIT;
                timer_n = '0;
            end
            CMD_WAIT: begin
                timer_n = timer_q + TMR_W'(1);
                if (timed_out) begin
                    state_n = ERR;
                    code_n  = 2'd1;
                end else if (cmd_complete) begin
                    cmd_irq_n = 1'b1;
                    cmd_inh_n = 1'b0;
                    if (!dp_q) begin
                        state_n = DONE;
                    end else if (blocks_left == '0) begin
                        state_n = ERR;
                        code_n  = 2'd3;
                    end else begin
                        state_n     = DAT_RUN;
                        dat_start_n = 1'b1;
                    end
                end
            end
            DAT_RUN: begin
                if (blk_done && blocks_left != '0)
                    blocks_n = blocks_left - BLK_CNT_W'(1);
                if (dat_error) begin
                    state_n = ERR;
                    code_n  = 2'd2;
                end else if (blk_done && blocks_left == BLK_CNT_W'(1)) begin
`ifdef XFER_AUTO_CMD12_EN
                    state_n = mb_q ? STOP_ISSUE : DONE;
`else
                    state_n = DONE;
`endif
                end else if (stop_req) begin
`ifdef XFER_AUTO_CMD12_EN
                    state_n = STOP_ISSUE;
`else
                    state_n = DONE;
`endif
                end
            end
`ifdef XFER_AUTO_CMD12_EN
            STOP_ISSUE: begin
                state_n = STOP_WAIT;
                timer_n = '0;
            end
            STOP_WAIT: begin
                timer_n = timer_q + TMR_W'(1);
                if (timed_out) begin
                    state_n = ERR;
                    code_n  = 2'd1;
                end else if (cmd_complete) begin
                    state_n = DONE;
                end
            end
`endif
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Issue, DONE and ERR states last one cycle, so these fire only on entry
`ifdef XFER_AUTO_CMD12_EN
        new_cmd_n = (state_n == CMD_ISSUE) || (state_n == STOP_ISSUE);
        if (state_n == STOP_ISSUE)
            idx_n = CMD12_IDX;
`else
        new_cmd_n = (state_n == CMD_ISSUE);
`endif
        if (state_n == DONE) begin
            xfer_irq_n = dp_q;
            cmd_inh_n  = 1'b0;
            dat_inh_n  = 1'b0;
        end
        if (state_n == ERR) begin
            err_n     = 1'b1;
            cmd_inh_n = 1'b0;
            dat_inh_n = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            dp_q          <= 1'b0;
            mb_q          <= 1'b0;
            new_cmd       <= 1'b0;
            cmd_index_out <= '0;
            dat_start     <= 1'b0;
            cmd_inhibit   <= 1'b0;
            dat_inhibit   <= 1'b0;
            cmd_done_irq  <= 1'b0;
            xfer_done_irq <= 1'b0;
            error         <= 1'b0;
            err_code      <= '0;
            blocks_left   <= '0;
        end else begin
            state_q       <= state_n;
            timer_q       <= timer_n;
            dp_q          <= dp_n;
            mb_q          <= mb_n;
            new_cmd       <= new_cmd_n;
            cmd_index_out <= idx_n;
            dat_start     <= dat_start_n;
            cmd_inhibit   <= cmd_inh_n;
            dat_inhibit   <= dat_inh_n;
            cmd_done_irq  <= cmd_irq_n;
            xfer_done_irq <= xfer_irq_n;
            error         <= err_n;
            err_code      <= code_n;
            blocks_left   <= blocks_n;
        end
    end

endmodule

// File: tb/tb_xfer_sequencer.sv
// tb/tb_xfer_sequencer.sv - scoreboard bench for xfer_sequencer
module tb_xfer_sequencer;

    localparam int K_NEW = 0, K_IRQ = 1, K_DST = 2, K_XFER = 3, K_ERR = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start_flag, data_present, multiple_blk;
    logic [5:0]  cmd_index;
    logic [15:0] block_cnt;
    logic        cmd_complete, cmd_timeout, blk_done, dat_error, stop_req;
    logic        new_cmd, dat_start, cmd_inhibit, dat_inhibit;
    logic        cmd_done_irq, xfer_done_irq, error;
    logic [5:0]  cmd_index_out;
    logic [1:0]  err_code;
    logic [15:0] blocks_left;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic error_d = 1'b0;
    int   t;

    xfer_sequencer #(.BLK_CNT_W(16), .TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RESET(RESET), .start_flag(start_flag), .cmd_index(cmd_index),
        .data_present(data_present), .multiple_blk(multiple_blk), .block_cnt(block_cnt),
        .cmd_complete(cmd_complete), .cmd_timeout(cmd_timeout), .blk_done(blk_done),
        .dat_error(dat_error), .stop_req(stop_req), .new_cmd(new_cmd),
        .cmd_index_out(cmd_index_out), .dat_start(dat_start), .cmd_inhibit(cmd_inhibit),
        .dat_inhibit(dat_inhibit), .cmd_done_irq(cmd_done_irq), .xfer_done_irq(xfer_done_irq),
        .error(error), .err_code(err_code), .blocks_left(blocks_left)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_NEW:   return "new_cmd";
            K_IRQ:   return "cmd_done_irq";
            K_DST:   return "dat_start";
            K_XFER:  return "xfer_done_irq";
            default: return "error_rise";
        endcase
    endfunction

    task automatic push(int kind, int c, int d);
        sb.push_back('{kind, c, d});
    endtask

    task automatic observe(int kind, int data);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected %s: got cycle %0d data %0d, required no event", kname(kind), cyc, data);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.data != data) begin
                n_bad++;
                $display("FAIL event %s: got %s@%0d data %0d, required %s@%0d data %0d",
                         kname(e.kind), kname(kind), cyc, data, kname(e.kind), e.cyc, e.data);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (new_cmd)             observe(K_NEW, int'(cmd_index_out));
        if (cmd_done_irq)        observe(K_IRQ, int'(cmd_inhibit));
        if (dat_start)           observe(K_DST, int'(blocks_left));
        if (xfer_done_irq)       observe(K_XFER, int'(blocks_left));
        if (error && !error_d)   observe(K_ERR, int'(err_code));
        error_d = error;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic to(int c);
        while (cyc < c) step();
    endtask

    task automatic start_cmd(int idx, logic dp, logic mb, int cnt);
        t = cyc;
        cmd_index = 6'(idx); data_present = dp; multiple_blk = mb; block_cnt = 16'(cnt);
        start_flag = 1'b1;
        push(K_NEW, t + 1, idx);
        step();
        start_flag = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; start_flag = 0; cmd_index = 0; data_present = 0; multiple_blk = 0;
        block_cnt = 0; cmd_complete = 0; cmd_timeout = 0; blk_done = 0; dat_error = 0; stop_req = 0;
        repeat (3) step();
        check("rst_new_cmd", new_cmd, 0);
        check("rst_inhibits", {cmd_inhibit, dat_inhibit}, 0);
        check("rst_error", {error, err_code}, 0);
        check("rst_blocks_left", blocks_left, 0);
        check("rst_cmd_index_out", cmd_index_out, 0);
        RESET = 1'b0;
        step(); step();

        // No-data command, index 8
        start_cmd(8, 0, 0, 0);
        check("t1_cmd_inhibit", cmd_inhibit, 1);
        check("t1_dat_inhibit", dat_inhibit, 0);
        to(t + 5); cmd_complete = 1; push(K_IRQ, t + 6, 0);
        step(); cmd_complete = 0;
        to(t + 7);
        check("t1_err", {error, err_code}, 0);
        check("t1_cmd_inhibit_end", cmd_inhibit, 0);
        step();

        // Three-block write
        start_cmd(25, 1, 1, 3);
        check("t2_dat_inhibit", dat_inhibit, 1);
        to(t + 3); cmd_complete = 1; push(K_IRQ, t + 4, 0); push(K_DST, t + 4, 3);
        step(); cmd_complete = 0;
        for (int i = 0; i < 3; i++) begin
            to(t + 6 + 2 * i); blk_done = 1;
            if (i == 2) begin
`ifdef XFER_AUTO_CMD12_EN
                push(K_NEW, t + 11, 12);
`else
                push(K_XFER, t + 11, 0);
`endif
            end
            step(); blk_done = 0;
            check("t2_blocks_left", blocks_left, 32'(2 - i));
        end
`ifdef XFER_AUTO_CMD12_EN
        to(t + 13); cmd_complete = 1; push(K_XFER, t + 14, 0);
        step(); cmd_complete = 0;
`endif
        step(); step();
        check("t2_inhibits_end", {cmd_inhibit, dat_inhibit}, 0);

        // Internal response timeout: 16 cycles in CMD_WAIT
        start_cmd(17, 0, 0, 0);
        push(K_ERR, t + 18, 1);
        to(t + 17);
        check("t3_no_early_error", error, 0);
        step();
        check("t3_err", {error, err_code}, 3'b101);
        check("t3_inhibits", {cmd_inhibit, dat_inhibit}, 0);
        step();
        check("t3_error_held", {error, err_code}, 3'b101);

        // cmd_timeout beats a same-cycle cmd_complete
        start_cmd(3, 0, 0, 0);
        check("t3b_error_cleared", {error, err_code}, 0);
        to(t + 4); cmd_timeout = 1; cmd_complete = 1; push(K_ERR, t + 5, 1);
        step(); cmd_timeout = 0; cmd_complete = 0;
        step();

        // Data error with the 2nd of 4 blocks
        start_cmd(24, 1, 1, 4);
        to(t + 3); cmd_complete = 1; push(K_IRQ, t + 4, 0); push(K_DST, t + 4, 4);
        step(); cmd_complete = 0;
        to(t + 5); blk_done = 1; step(); blk_done = 0;
        to(t + 7); blk_done = 1; dat_error = 1; push(K_ERR, t + 8, 2);
        step(); blk_done = 0; dat_error = 0;
        check("t4_blocks_left", blocks_left, 2);
        check("t4_dat_inhibit", dat_inhibit, 0);
        step();

        // Zero block count, plus start_flag while busy
        start_cmd(18, 1, 1, 0);
        to(t + 3); cmd_index = 6'd5; block_cnt = 16'd7; start_flag = 1;
        step(); start_flag = 0;
        to(t + 5); cmd_complete = 1; push(K_IRQ, t + 6, 0); push(K_ERR, t + 6, 3);
        step(); cmd_complete = 0;
        check("t5_blocks_left", blocks_left, 0);
        check("t5_cmd_index_out", cmd_index_out, 18);
        step();

        // stop_req mid-transfer
        start_cmd(40, 1, 1, 5);
        check("t6_error_cleared", {error, err_code}, 0);
        to(t + 3); cmd_complete = 1; push(K_IRQ, t + 4, 0); push(K_DST, t + 4, 5);
        step(); cmd_complete = 0;
        to(t + 5); blk_done = 1; step(); blk_done = 0;
        to(t + 7); stop_req = 1;
`ifdef XFER_AUTO_CMD12_EN
        push(K_NEW, t + 8, 12);
`else
        push(K_XFER, t + 8, 4);
`endif
        step(); stop_req = 0;
`ifdef XFER_AUTO_CMD12_EN
        check("t6_dat_inhibit_stop", dat_inhibit, 1);
        to(t + 10); cmd_complete = 1; push(K_XFER, t + 11, 4);
        step(); cmd_complete = 0;
`endif
        step();
        check("t6_blocks_frozen", blocks_left, 4);
        check("t6_dat_inhibit_end", dat_inhibit, 0);

        // Single-block transfer ignores block_cnt
        start_cmd(51, 1, 0, 9);
        to(t + 3); cmd_complete = 1; push(K_IRQ, t + 4, 0); push(K_DST, t + 4, 1);
        step(); cmd_complete = 0;
        to(t + 5); blk_done = 1; push(K_XFER, t + 6, 0);
        step(); blk_done = 0;
        step();

        // Reset during DAT_RUN
        start_cmd(33, 1, 1, 2);
        to(t + 3); cmd_complete = 1; push(K_IRQ, t + 4, 0); push(K_DST, t + 4, 2);
        step(); cmd_complete = 0;
        to(t + 6); RESET = 1;
        step();
        check("t8_rst_inhibits", {cmd_inhibit, dat_inhibit}, 0);
        check("t8_rst_blocks_left", blocks_left, 0);
        check("t8_rst_cmd_index_out", cmd_index_out, 0);
        RESET = 0;
        repeat (3) step();

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
